// File: rtl/hdc_ngram_encoder.sv
// Streaming hyperdimensional n-gram text encoder.
// Accepts one character per cycle, binds each window of NGRAM item vectors into an
// n-gram hypervector, bundles all n-grams of a message with per-bit counters and
// emits the majority-thresholded D-bit message hypervector once per frame.
module hdc_ngram_encoder #(
    parameter int            D       = 1024,
    parameter int            NGRAM   = 3,
    parameter int            CHAR_W  = 8,
    parameter int            MAX_LEN = 160,
    parameter logic [D-1:0]  SEED    = {D/16{16'hACE1}},
    localparam int           CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              in_last,
    output logic              hv_valid,
    input  logic              hv_ready,
    output logic [D-1:0]      hv_data,
    output logic [CNT_W-1:0]  hv_ngrams,
    output logic              hv_short,
    output logic              hv_trunc
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_THRESH = 2'd2;
    localparam logic [1:0] ST_OUT    = 2'd3;

    logic [1:0]       state;
    logic             drain;        // THRESH waits one cycle for the add pipeline
    logic [D-1:0]     hist [NGRAM]; // hist[0] is the newest item vector
    logic [D-1:0]     hist_next [NGRAM];
    logic [CNT_W-1:0] char_cnt;     // characters kept so far (saturates at MAX_LEN)
    logic             trunc;
    logic [D-1:0]     item_vec;
    logic [D-1:0]     gram;
    logic [D-1:0]     g_reg;
    logic             add_pend;
    logic [CNT_W-1:0] cnt [D];
    logic [CNT_W-1:0] n_cnt;
    logic [D-1:0]     thr;
    logic             accept;
    logic             in_window;
    logic             form_gram;
    logic             enter_out;

    // Rotate left by s positions (0 <= s < D).
    function automatic logic [D-1:0] rol(input logic [D-1:0] x, input int s);
        logic [2*D-1:0] t;
        t = {x, x} << s;
        return t[2*D-1:D];
    endfunction

    assign in_ready  = reset && (state == ST_IDLE || state == ST_ACCUM);
    assign accept    = in_valid && in_ready;
    assign in_window = (char_cnt < CNT_W'(MAX_LEN));
    assign form_gram = in_window && ((int'(char_cnt) + 1) >= NGRAM);
    assign enter_out = (state == ST_THRESH) && !drain;
    assign item_vec  = rol(SEED, int'(32'(in_char) % 32'(D)));

    // Next history contents and the n-gram bound from them.
    always_comb begin
        // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
        hist_next[0] = item_vec;
        for (int j = 1; j < NGRAM; j++) begin
            hist_next[j] = hist[j-1];
        end
        gram = '0;
        for (int j = 0; j < NGRAM; j++) begin
            gram = gram ^ rol(hist_next[j], j);
        end
    end

    // Majority threshold with the seed vector breaking exact ties.
    always_comb begin
        thr = '0;
        if (n_cnt != '0) begin
            for (int i = 0; i < D; i++) begin
                if ({cnt[i], 1'b0} > {1'b0, n_cnt}) begin
                    thr[i] = 1'b1;
                end else if ({cnt[i], 1'b0} == {1'b0, n_cnt}) begin
                    thr[i] = SEED[i];
                end
            end
        end
    end

    // Frame control: accumulate, drain the adder, threshold, then hold the result.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!reset) begin
            state <= ST_IDLE;
            drain <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        state <= in_last ? ST_THRESH : ST_ACCUM;
                        drain <= in_last;
                    end
                end
                ST_THRESH: begin
                    if (drain) drain <= 1'b0;
                    else       state <= ST_OUT;
                end
                default: begin
                    if (hv_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

    // Character history, kept-character count and truncation flag.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: hist and cnt are flop arrays, not RAM, so clearing them in reset is intended.
        if (!reset) begin
            for (int j = 0; j < NGRAM; j++) hist[j] <= '0;
            char_cnt <= '0;
            trunc    <= 1'b0;
        end else if (enter_out) begin
            for (int j = 0; j < NGRAM; j++) hist[j] <= '0;
            char_cnt <= '0;
            trunc    <= 1'b0;
        end else if (accept) begin
            if (in_window) begin
                for (int j = 0; j < NGRAM; j++) hist[j] <= hist_next[j];
                char_cnt <= char_cnt + 1'b1;
            end else begin
                trunc <= 1'b1;
            end
        end
    end

    // Register each completed n-gram so the counter add is off the item/bind path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_reg    <= '0;
            add_pend <= 1'b0;
        end else begin
            add_pend <= accept && form_gram;
            if (accept && form_gram) g_reg <= gram;
        end
    end

    // Per-bit bundling counters and n-gram count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) cnt[i] <= '0;
            n_cnt <= '0;
        end else if (enter_out) begin
            for (int i = 0; i < D; i++) cnt[i] <= '0;
            n_cnt <= '0;
        end else if (add_pend) begin
            for (int i = 0; i < D; i++) cnt[i] <= cnt[i] + CNT_W'(g_reg[i]);
            n_cnt <= n_cnt + 1'b1;
        end
    end

    // Output hypervector, held until the downstream stage takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hv_valid  <= 1'b0;
            hv_data   <= '0;
            hv_ngrams <= '0;
            hv_short  <= 1'b0;
            hv_trunc  <= 1'b0;
        end else if (enter_out) begin
            hv_valid  <= 1'b1;
            hv_data   <= thr;
            hv_ngrams <= n_cnt;
            hv_short  <= (n_cnt == '0);
            hv_trunc  <= trunc;
        end else if (state == ST_OUT && hv_ready) begin
            hv_valid  <= 1'b0;
        end
    end

endmodule
